mem_io_responder: RTL and testbench
===================================

// Module: mem_io_responder
// PURPOSE
//  Memory-side responder for the multicycle CPU's load/store bus; services every controller memory request.
//  Addresses below IO_BASE go to block RAM. Addresses at or above IO_BASE hit an on-chip register page: LEDs, switches, debounced buttons and a millisecond timer.
//  Sits between the datapath's address/data/write-enable outputs and the RAM plus board pins.
// PARAMETERS
//  DATA_W    16       bus data and address width
//  IO_BASE   16'hFF00 first address of I/O page (page = 256 words, addr[3:0] selects register)
//  NUM_BTN   4        number of push buttons
//  PRESCALE  50000    clk cycles per timer tick (1 ms at 50 MHz)
//  DEBOUNCE  20       ticks a button level must be stable before accepted
// PORTS
//  clk        in   1        system clock
//  reset      in   1        async active-low reset
//  mem_addr   in   DATA_W   word address from datapath
//  mem_wdata  in   DATA_W   store data
//  mem_we     in   1        store strobe, one cycle per store
//  mem_re     in   1        load strobe, one cycle; enables read side effects
//  mem_rdata  out  DATA_W   load data, valid cycle after address
//  ram_addr   out  DATA_W   BRAM address (= mem_addr, combinational)
//  ram_wdata  out  DATA_W   BRAM write data (= mem_wdata)
//  ram_we     out  1        mem_we & (mem_addr < IO_BASE)
//  ram_rdata  in   DATA_W   BRAM sync read data (1-cycle latency)
//  sw_in      in   DATA_W   raw switches (asynchronous)
//  btn_in     in   NUM_BTN  raw buttons, active-high, asynchronous
//  led_out    out  DATA_W   LED register
//  timer_irq  out  1        copy of timer expired flag
// BEHAVIOUR
//  Reset: led_out, mem_rdata, timer count/cmp/ctrl, btn status, prescaler, all debounce FSMs and sync flops = 0; timer_irq = 0.
//  Sync: sw_in and btn_in each pass through a 2-flop synchronizer before any use.
//  Register map (offset = addr[3:0] in I/O page):
//   0 LED: RW. 1 SW: RO synced switches. 2 BTN: RO press flags, read-to-clear.
//   3 TCNT: RW. 4 TCMP: RW. 5 TCTL: bit0 enable RW, bit1 expired; write 1 to bit1 clears it.
//   Other offsets read 0; writes to them are ignored.
//  Read timing: region and I/O read value are registered every cycle from mem_addr.
//   On cycle N+1, mem_rdata = ram_rdata if region(N) was RAM, else the registered I/O value.
//   mem_rdata holds between accesses; there is no ready signal, and latency is fixed at 1 cycle.
//  Stores: I/O registers update on the clk edge with mem_we=1; written value is visible on a read one cycle later.
//  BTN clear-on-read: only when mem_re=1 at offset 2. Only bits returned in that read are cleared.
//   An event in the same cycle as the clear wins (bit stays 1).
//  Debounce FSM per button: IDLE -> PRESS_WAIT when the synced level goes 1.
//   PRESS_WAIT -> PRESSED after DEBOUNCE consecutive ticks at 1; falls back to IDLE on any 0.
//   Entering PRESSED sets BTN bit.
//   PRESSED -> RELEASE_WAIT on 0. RELEASE_WAIT -> IDLE after DEBOUNCE ticks at 0; returns to PRESSED on any 1.
//   Counter is 8 bits and saturates.
//  Prescaler: counts 0..PRESCALE-1 continuously; tick = 1-cycle pulse at wrap. It does not reset on TCNT writes.
//  Timer: if enable and tick: TCNT==TCMP -> TCNT<=0 and expired<=1; otherwise TCNT<=TCNT+1 (16-bit wrap).
//   A TCNT write in the same cycle as a tick wins over the increment.
//   A set and a clear of expired in the same cycle: set wins.
//  Reset mid-access: all state clears immediately; the next read after reset release returns the reset value.
// TESTING
//  Store 16'h00A5 to FF00, then load FF00 -> led_out=00A5 the next cycle; mem_rdata=00A5 one cycle after the load address.
//  Store 1234 to 0010, then load 0010 -> ram_we only for the RAM store; led_out unchanged; mem_rdata=1234.
//  btn_in[2] held 1 for DEBOUNCE+2 ticks -> BTN reads 0004; a second read returns 0000.
//   A 3-tick glitch yields no flag.
//  TCMP=3, TCTL=1 -> after 4 ticks TCNT=0 and timer_irq=1; write TCTL=3 -> irq=0, enable kept.
//  BTN set coincident with its clearing read; and TCNT write coincident with tick -> bit stays 1; TCNT = written value.
//  Assert reset mid-countdown with LED=FFFF -> all outputs 0 asynchronously; load FF05 after release returns 0000.

Source files
------------

// File: rtl/mem_io_responder.sv
// Memory-side responder for the multicycle CPU load/store bus: routes low addresses to block RAM
// and services an I/O register page (LEDs, switches, debounced buttons, millisecond timer).
module mem_io_responder #(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] IO_BASE  = 16'hFF00,
  parameter int                NUM_BTN  = 4,
  parameter int                PRESCALE = 50000,
  parameter int                DEBOUNCE = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_we,
  input  logic               mem_re,
  output logic [DATA_W-1:0]  mem_rdata,
  output logic [DATA_W-1:0]  ram_addr,
  output logic [DATA_W-1:0]  ram_wdata,
  output logic               ram_we,
  input  logic [DATA_W-1:0]  ram_rdata,
  input  logic [DATA_W-1:0]  sw_in,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [DATA_W-1:0]  led_out,
  output logic               timer_irq
);

  localparam logic [3:0] OFF_LED  = 4'd0;
  localparam logic [3:0] OFF_SW   = 4'd1;
  localparam logic [3:0] OFF_BTN  = 4'd2;
  localparam logic [3:0] OFF_TCNT = 4'd3;
  localparam logic [3:0] OFF_TCMP = 4'd4;
  localparam logic [3:0] OFF_TCTL = 4'd5;

  localparam int                PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [7:0]        DEB_LAST = 8'(DEBOUNCE - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} deb_state_e;

  logic             is_io;
  logic [3:0]       offset;
  logic             io_we;

  assign is_io     = (mem_addr >= IO_BASE);
  assign offset    = mem_addr[3:0];
  assign io_we     = mem_we && is_io;
  assign ram_addr  = mem_addr;
  assign ram_wdata = mem_wdata;
  assign ram_we    = mem_we && !is_io;

  // ---------------------------------------------------------------- synchronizers
  logic [DATA_W-1:0]  sw_meta, sw_sync;
  logic [NUM_BTN-1:0] btn_meta, btn_sync;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      sw_meta  <= sw_in;
      sw_sync  <= sw_meta;
      btn_meta <= btn_in;
      btn_sync <= btn_meta;
    end
  end

  // ---------------------------------------------------------------- prescaler
  logic [PRE_W-1:0] pre_q;
  logic             tick;

  assign tick = (pre_q == PRE_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pre_q <= '0;
    else        pre_q <= tick ? '0 : pre_q + 1'b1;
  end

  // ---------------------------------------------------------------- debounce FSMs
  deb_state_e         deb_q     [NUM_BTN];
  deb_state_e         deb_d     [NUM_BTN];
  logic [7:0]         deb_cnt_q [NUM_BTN];
  logic [7:0]         deb_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] press_set;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        deb_q[i]     <= IDLE;
        deb_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        deb_q[i]     <= deb_d[i];
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      // NOTE: defaults first so no path through the case leaves a latch behind.
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = deb_cnt_q[i];
      case (deb_q[i])
        IDLE: if (btn_sync[i]) begin
          deb_d[i]     = PRESS_WAIT;
          deb_cnt_d[i] = '0;
        end
        PRESS_WAIT: if (!btn_sync[i]) begin
          deb_d[i]     = IDLE;
          deb_cnt_d[i] = '0;
        end else if (tick) begin
          if (deb_cnt_q[i] >= DEB_LAST) begin
            deb_d[i]     = PRESSED;
            deb_cnt_d[i] = '0;
          end else begin
            deb_cnt_d[i] = sat_inc(deb_cnt_q[i]);
          end
        end
        PRESSED: if (!btn_sync[i]) begin
          deb_d[i]     = RELEASE_WAIT;
          deb_cnt_d[i] = '0;
        end
        RELEASE_WAIT: if (btn_sync[i]) begin
          deb_d[i]     = PRESSED;
          deb_cnt_d[i] = '0;
        end else if (tick) begin
          if (deb_cnt_q[i] >= DEB_LAST) begin
            deb_d[i]     = IDLE;
            deb_cnt_d[i] = '0;
          end else begin
            deb_cnt_d[i] = sat_inc(deb_cnt_q[i]);
          end
        end
        default: begin
          deb_d[i]     = IDLE;
          deb_cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Only a qualified press flags; a release bounce back into PRESSED is not a new press.
  always_comb begin
    press_set = '0;
    for (int i = 0; i < NUM_BTN; i++)
      press_set[i] = (deb_q[i] == PRESS_WAIT) && (deb_d[i] == PRESSED);
  end

  // ---------------------------------------------------------------- register page
  logic [NUM_BTN-1:0] btn_flags_q;
  logic [NUM_BTN-1:0] btn_clr_mask;
  logic [DATA_W-1:0]  tcnt_q, tcmp_q;
  logic               tctl_en_q, expired_q;
  logic               tmr_step, tmr_match;

  // The read returns the current flags, so clearing exactly those bits clears only what was seen.
  assign btn_clr_mask = (mem_re && is_io && offset == OFF_BTN) ? btn_flags_q : '0;
  assign tmr_step     = tctl_en_q && tick;
  assign tmr_match    = (tcnt_q == tcmp_q);
  assign timer_irq    = expired_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_out     <= '0;
      btn_flags_q <= '0;
      tcnt_q      <= '0;
      tcmp_q      <= '0;
      tctl_en_q   <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      btn_flags_q <= (btn_flags_q & ~btn_clr_mask) | press_set;

      if (io_we && offset == OFF_LED)  led_out <= mem_wdata;
      if (io_we && offset == OFF_TCMP) tcmp_q  <= mem_wdata;

      if (io_we && offset == OFF_TCNT) tcnt_q <= mem_wdata;
      else if (tmr_step)               tcnt_q <= tmr_match ? '0 : tcnt_q + 1'b1;

      if (io_we && offset == OFF_TCTL) tctl_en_q <= mem_wdata[0];

      if (tmr_step && tmr_match)                          expired_q <= 1'b1;
      else if (io_we && offset == OFF_TCTL && mem_wdata[1]) expired_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- read path
  logic [DATA_W-1:0] io_rdata_d, io_rdata_q;
  logic              rd_ram_q;

  always_comb begin
    io_rdata_d = '0;
    case (offset)
      OFF_LED:  io_rdata_d = led_out;
      OFF_SW:   io_rdata_d = sw_sync;
      OFF_BTN:  io_rdata_d = DATA_W'(btn_flags_q);
      OFF_TCNT: io_rdata_d = tcnt_q;
      OFF_TCMP: io_rdata_d = tcmp_q;
      OFF_TCTL: io_rdata_d = {{(DATA_W-2){1'b0}}, expired_q, tctl_en_q};
      default:  io_rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ram_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      rd_ram_q   <= !is_io;
      io_rdata_q <= io_rdata_d;
    end
  end

  assign mem_rdata = rd_ram_q ? ram_rdata : io_rdata_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder with a short prescaler and debounce window
// and a behavioural synchronous-read RAM behind the BRAM port.
module tb_mem_io_responder;

  localparam int PRESCALE = 4;
  localparam int DEBOUNCE = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] mem_addr = '0, mem_wdata = '0;
  logic        mem_we = 1'b0, mem_re = 1'b0;
  logic [15:0] mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        ram_we;
  logic [15:0] sw_in = '0;
  logic [3:0]  btn_in = '0;
  logic [15:0] led_out;
  logic        timer_irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] ram_mem [0:255];

  mem_io_responder #(
    .DATA_W(16), .IO_BASE(16'hFF00), .NUM_BTN(4), .PRESCALE(PRESCALE), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .sw_in(sw_in), .btn_in(btn_in), .led_out(led_out), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM, one cycle latency, read-before-write.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr[7:0]];
  end

  // Posedges since reset release; the prescaler ticks on posedges where this becomes a multiple of 4.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // All tasks are entered at a negedge and leave at a negedge.
  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data, output logic we_seen);
    mem_addr = addr; mem_wdata = data; mem_we = 1'b1;
    #1 we_seen = ram_we;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
    mem_addr = addr; mem_re = 1'b1;
    @(negedge clk);
    mem_re = 1'b0;
    data = mem_rdata;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (led_out !== 16'h0000) begin failures++; $display("FAIL reset_led: got %h want 0000", led_out); end
    checks++; if (mem_rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata: got %h want 0000", mem_rdata); end
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b want 0", timer_irq); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_led;
    logic we; logic [15:0] d;
    bus_write(16'hFF00, 16'h00A5, we);
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL led_ram_we: got %b want 0", we); end
    checks++; if (led_out !== 16'h00A5) begin failures++; $display("FAIL led_out: got %h want 00a5", led_out); end
    bus_read(16'hFF00, d);
    checks++; if (d !== 16'h00A5) begin failures++; $display("FAIL led_read: got %h want 00a5", d); end
  endtask

  task automatic test_ram;
    logic we; logic [15:0] d;
    bus_write(16'h0010, 16'h1234, we);
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL ram_we: got %b want 1", we); end
    checks++; if (led_out !== 16'h00A5) begin failures++; $display("FAIL ram_led_kept: got %h want 00a5", led_out); end
    bus_read(16'h0010, d);
    checks++; if (d !== 16'h1234) begin failures++; $display("FAIL ram_read: got %h want 1234", d); end
  endtask

  task automatic test_sw_unmapped;
    logic we; logic [15:0] d;
    sw_in = 16'hBEEF;
    repeat (3) @(negedge clk);
    bus_read(16'hFF01, d);
    checks++; if (d !== 16'hBEEF) begin failures++; $display("FAIL sw_read: got %h want beef", d); end
    bus_write(16'hFF08, 16'h5A5A, we);
    bus_read(16'hFF08, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL unmapped_read: got %h want 0000", d); end
    bus_read(16'hFF00, d);
    checks++; if (d !== 16'h00A5) begin failures++; $display("FAIL unmapped_no_alias: got %h want 00a5", d); end
  endtask

  task automatic test_button;
    logic [15:0] d;
    btn_in[2] = 1'b1;
    repeat ((DEBOUNCE + 2) * PRESCALE + 4) @(negedge clk);
    btn_in[2] = 1'b0;
    repeat (32) @(negedge clk);
    bus_read(16'hFF02, d);
    checks++; if (d !== 16'h0004) begin failures++; $display("FAIL btn_press: got %h want 0004", d); end
    bus_read(16'hFF02, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL btn_cleared: got %h want 0000", d); end
    btn_in[1] = 1'b1;
    repeat (3 * PRESCALE) @(negedge clk);
    btn_in[1] = 1'b0;
    repeat (20) @(negedge clk);
    bus_read(16'hFF02, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL btn_glitch: got %h want 0000", d); end
  endtask

  task automatic test_timer;
    logic we; logic [15:0] d;
    bus_write(16'hFF04, 16'h0003, we);
    bus_write(16'hFF05, 16'h0001, we);
    repeat (4 * PRESCALE) @(negedge clk);
    checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL tmr_irq_set: got %b want 1", timer_irq); end
    bus_read(16'hFF03, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL tmr_cnt_wrap: got %h want 0000", d); end
    bus_read(16'hFF05, d);
    checks++; if (d !== 16'h0003) begin failures++; $display("FAIL tmr_ctl_expired: got %h want 0003", d); end
    bus_write(16'hFF05, 16'h0003, we);
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL tmr_irq_clear: got %b want 0", timer_irq); end
    bus_read(16'hFF05, d);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL tmr_en_kept: got %h want 0001", d); end
  endtask

  task automatic test_coincident;
    logic we; logic [15:0] d;
    // First press leaves bit 0 set and unread.
    btn_in[0] = 1'b1;
    repeat (32) @(negedge clk);
    btn_in[0] = 1'b0;
    repeat (32) @(negedge clk);
    // Second press qualifies 19 posedges after the edge following a tick-aligned raise.
    while (cyc % PRESCALE != 0) @(negedge clk);
    btn_in[0] = 1'b1;
    repeat (19) @(negedge clk);
    bus_read(16'hFF02, d);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL btn_coinc_read: got %h want 0001", d); end
    bus_read(16'hFF02, d);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL btn_set_wins: got %h want 0001", d); end
    bus_read(16'hFF02, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL btn_coinc_cleared: got %h want 0000", d); end
    btn_in[0] = 1'b0;
    repeat (32) @(negedge clk);
    // TCNT write landing on a tick edge.
    bus_write(16'hFF04, 16'hFFFF, we);
    while (cyc % PRESCALE != PRESCALE - 1) @(negedge clk);
    bus_write(16'hFF03, 16'h0100, we);
    bus_read(16'hFF03, d);
    checks++; if (d !== 16'h0100) begin failures++; $display("FAIL tcnt_write_wins: got %h want 0100", d); end
  endtask

  task automatic test_reset_mid;
    logic we; logic [15:0] d;
    bus_write(16'hFF03, 16'h0000, we);
    bus_write(16'hFF04, 16'h0000, we);
    repeat (2 * PRESCALE) @(negedge clk);
    checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL pre_reset_irq: got %b want 1", timer_irq); end
    bus_write(16'hFF00, 16'hFFFF, we);
    bus_read(16'hFF00, d);
    checks++; if (d !== 16'hFFFF) begin failures++; $display("FAIL pre_reset_led: got %h want ffff", d); end
    #2 reset = 1'b0;
    #1;
    checks++; if (led_out !== 16'h0000) begin failures++; $display("FAIL async_led: got %h want 0000", led_out); end
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL async_irq: got %b want 0", timer_irq); end
    checks++; if (mem_rdata !== 16'h0000) begin failures++; $display("FAIL async_rdata: got %h want 0000", mem_rdata); end
    @(negedge clk);
    reset = 1'b1;
    bus_read(16'hFF05, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL post_reset_tctl: got %h want 0000", d); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = '0;
    @(negedge clk);
    test_reset;
    test_led;
    test_ram;
    test_sw_unmapped;
    test_button;
    test_timer;
    test_coincident;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
